event_capture_arbiter_4ch: RTL and testbench

//  Upstream stage of the 4-bit priority encoder. Captures per-channel event pulses into sticky

---
 rtl/event_capture_arbiter_4ch_pkg.sv | 25 ++
 rtl/event_capture_arbiter_4ch_enc.sv | 21 ++
 rtl/event_capture_arbiter_4ch.sv | 103 ++++++++++
 tb/tb_event_capture_arbiter_4ch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/event_capture_arbiter_4ch_pkg.sv
// Shared constants and helpers for the 4-channel event capture arbiter.
// Channel count, index width and the one-hot / population-count helpers live here.
package event_capture_arbiter_4ch_pkg;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;
    localparam int POP_W  = 3;

    function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/event_capture_arbiter_4ch_enc.sv
// Combinational lowest-index-first priority encoder over the pending vector.
module priority_encoder_4bit
    import event_capture_arbiter_4ch_pkg::*;
(
    input  logic [NUM_CH-1:0] pending_i,
    output logic [IDX_W-1:0]  enc_idx_o,
    output logic              enc_valid_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        enc_valid_o = |pending_i;
        enc_idx_o   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending_i[i]) begin
                enc_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/event_capture_arbiter_4ch.sv
// Captures per-channel event pulses into sticky pending bits and hands out one granted
// channel index per valid/ready handshake, counting events lost to still-pending channels.
module event_capture_arbiter_4ch
    import event_capture_arbiter_4ch_pkg::*;
#(
    parameter int EDGE_DETECT = 0,
    parameter int DROP_CNT_W  = 8
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     event_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [IDX_W-1:0]      out_idx_o,
    output logic [NUM_CH-1:0]     hot_vector_o,
    output logic [NUM_CH-1:0]     drop_flag_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
    input  logic                  clear_drop_i,
    output logic                  busy_o
);

    localparam int                  SUM_W     = DROP_CNT_W + POP_W;
    localparam logic [SUM_W-1:0]    CNT_MAX   = SUM_W'({DROP_CNT_W{1'b1}});
    localparam logic [NUM_CH-1:0]   EDGE_MASK = (EDGE_DETECT != 0) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}};

    logic [NUM_CH-1:0]     r_event_d;
    logic [NUM_CH-1:0]     r_pending;
    logic [NUM_CH-1:0]     r_drop_flag;
    logic                  r_out_valid;
    logic [IDX_W-1:0]      r_out_idx;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic [NUM_CH-1:0]     w_ev;
    logic                  w_load;
    logic [IDX_W-1:0]      w_enc_idx;
    logic                  w_enc_valid;
    logic [NUM_CH-1:0]     w_grant_mask;
    logic [NUM_CH-1:0]     w_drop;
    logic [POP_W-1:0]      w_drop_pop;
    logic [SUM_W-1:0]      w_cnt_sum;
    logic [DROP_CNT_W-1:0] w_cnt_next;

    priority_encoder_4bit u_enc (
        .pending_i   (r_pending),
        .enc_idx_o   (w_enc_idx),
        .enc_valid_o (w_enc_valid)
    );

    // In level mode the mask is zero, so every high cycle counts as an event.
    assign w_ev         = event_i & ~(r_event_d & EDGE_MASK);
    assign w_load       = ~r_out_valid | out_ready_i;
    assign w_grant_mask = (w_load & w_enc_valid) ? onehot(w_enc_idx) : '0;

    // A channel that was just moved into the output register is free to capture again.
    assign w_drop       = w_ev & r_pending & ~w_grant_mask;
    assign w_drop_pop   = popcount(w_drop);
    assign w_cnt_sum    = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_pop);
    assign w_cnt_next   = (w_cnt_sum > CNT_MAX) ? {DROP_CNT_W{1'b1}} : w_cnt_sum[DROP_CNT_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_event_d <= '0;
            r_pending <= '0;
        end else begin
            r_event_d <= event_i;
            r_pending <= (r_pending & ~w_grant_mask) | w_ev;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_enc_valid;
            if (w_enc_valid) begin
                r_out_idx <= w_enc_idx;
            end
        end
    end

    // Clear wins over any drop arriving in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_flag <= '0;
            r_drop_cnt  <= '0;
        end else if (clear_drop_i) begin
            r_drop_flag <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_drop_flag <= r_drop_flag | w_drop;
            r_drop_cnt  <= w_cnt_next;
        end
    end

    assign out_valid_o  = r_out_valid;
    assign out_idx_o    = r_out_idx;
    assign hot_vector_o = r_pending;
    assign drop_flag_o  = r_drop_flag;
    assign drop_cnt_o   = r_drop_cnt;
    assign busy_o       = (|r_pending) | r_out_valid;

endmodule

// File: tb/tb_event_capture_arbiter_4ch.sv
// Directed bench: grants are checked by a scoreboard monitor, state by directed checks.
module tb_event_capture_arbiter_4ch;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] event_v;
    logic       ready;
    logic       clear_drop;
    logic       out_valid;
    logic [1:0] out_idx;
    logic [3:0] hot;
    logic [3:0] drop_flag;
    logic [1:0] drop_cnt;
    logic       busy;

    logic [3:0] e_event;
    logic       e_ready;
    logic       e_valid;
    logic [1:0] e_idx;
    logic [3:0] e_hot;
    logic [3:0] e_flag;
    logic [7:0] e_cnt;
    logic       e_busy;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int e_grants = 0;

    always #5 clk = ~clk;

    event_capture_arbiter_4ch #(.EDGE_DETECT(0), .DROP_CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .event_i(event_v), .out_ready_i(ready),
        .out_valid_o(out_valid), .out_idx_o(out_idx), .hot_vector_o(hot),
        .drop_flag_o(drop_flag), .drop_cnt_o(drop_cnt), .clear_drop_i(clear_drop),
        .busy_o(busy)
    );

    event_capture_arbiter_4ch #(.EDGE_DETECT(1), .DROP_CNT_W(8)) dut_e (
        .clk(clk), .reset_n(reset_n), .event_i(e_event), .out_ready_i(e_ready),
        .out_valid_o(e_valid), .out_idx_o(e_idx), .hot_vector_o(e_hot),
        .drop_flag_o(e_flag), .drop_cnt_o(e_cnt), .clear_drop_i(1'b0),
        .busy_o(e_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted grant must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_grant: got idx %0d, expected none", out_idx);
            end else begin
                int e;
                e = exp_q.pop_front();
                $display("grant idx=%0d expected=%0d", out_idx, e);
                check("grant_idx", 32'(out_idx), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && e_valid === 1'b1 && e_ready === 1'b1) begin
            e_grants++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin
            step();
            k++;
        end
        @(negedge clk);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        event_v    = 4'b0;
        ready      = 1'b0;
        clear_drop = 1'b0;
        e_event    = 4'b0;
        e_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_idx",   32'(out_idx),   0);
        check("rst_hot",   32'(hot),       0);
        check("rst_flag",  32'(drop_flag), 0);
        check("rst_cnt",   32'(drop_cnt),  0);
        check("rst_busy",  32'(busy),      0);
        step();
        reset_n = 1'b1;

        // 1: single event on ch2
        step(); event_v = 4'b0100; ready = 1'b1; exp_q.push_back(2);
        step(); event_v = 4'b0000;
        @(negedge clk);
        check("t1_hot_set", 32'(hot), 32'b0100);
        check("t1_valid_lo", 32'(out_valid), 0);
        step(); @(negedge clk);
        check("t1_valid", 32'(out_valid), 1);
        check("t1_idx", 32'(out_idx), 2);
        check("t1_hot_clr", 32'(hot), 0);
        step(); @(negedge clk);
        check("t1_valid_end", 32'(out_valid), 0);
        check("t1_busy_end", 32'(busy), 0);

        // 2: three channels back to back
        step(); event_v = 4'b1011;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        step(); event_v = 4'b0000;
        @(negedge clk);
        check("t2_hot", 32'(hot), 32'b1011);
        wait_idle("t2");

        // 3: backpressure holds idx 1; re-event on the held channel is not a drop
        step(); ready = 1'b0; event_v = 4'b0110;
        step(); event_v = 4'b0000;
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 1);
            check("t3_hold_idx", 32'(out_idx), 1);
            check("t3_hold_hot", 32'(hot), 32'b0100);
            step();
        end
        event_v = 4'b0010;
        step(); event_v = 4'b0000;
        @(negedge clk);
        check("t3_rearm_hot", 32'(hot), 32'b0110);
        check("t3_rearm_nodrop", 32'(drop_cnt), 0);
        step(); ready = 1'b1;
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(2);
        wait_idle("t3");

        // 4: held ch3 event saturates the 2-bit drop counter, then clear
        step(); ready = 1'b0; event_v = 4'b1000;
        exp_q.push_back(3); exp_q.push_back(3);
        repeat (6) step();
        event_v = 4'b0000;
        @(negedge clk);
        check("t4_flag", 32'(drop_flag), 32'b1000);
        check("t4_cnt_sat", 32'(drop_cnt), 3);
        check("t4_idx", 32'(out_idx), 3);
        step(); event_v = 4'b1000; clear_drop = 1'b1;
        step(); event_v = 4'b0000; clear_drop = 1'b0;
        @(negedge clk);
        check("t4_flag_clr", 32'(drop_flag), 0);
        check("t4_cnt_clr", 32'(drop_cnt), 0);
        step(); ready = 1'b1;
        wait_idle("t4");

        // 5: event on ch0 in the very cycle ch0 is granted
        step(); event_v = 4'b0001; exp_q.push_back(0); exp_q.push_back(0);
        step();
        step(); event_v = 4'b0000;
        @(negedge clk);
        check("t5_valid", 32'(out_valid), 1);
        check("t5_idx", 32'(out_idx), 0);
        check("t5_hot", 32'(hot), 32'b0001);
        check("t5_cnt", 32'(drop_cnt), 0);
        check("t5_flag", 32'(drop_flag), 0);
        wait_idle("t5");

        // 6: asynchronous reset mid-burst
        step(); ready = 1'b0; event_v = 4'b1111;
        step();
        step(); event_v = 4'b0000;
        @(negedge clk);
        check("t6_hot_full", 32'(hot), 32'b1111);
        check("t6_valid", 32'(out_valid), 1);
        check("t6_cnt", 32'(drop_cnt), 3);
        check("t6_flag", 32'(drop_flag), 32'b1110);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_idx", 32'(out_idx), 0);
        check("t6_rst_hot", 32'(hot), 0);
        check("t6_rst_flag", 32'(drop_flag), 0);
        check("t6_rst_cnt", 32'(drop_cnt), 0);
        check("t6_rst_busy", 32'(busy), 0);
        step(); step(); reset_n = 1'b1; ready = 1'b1;
        repeat (5) step();
        @(negedge clk);
        check("t6_no_grant", 32'(out_valid), 0);
        check("t6_idle", 32'(busy), 0);
        step(); event_v = 4'b0100; exp_q.push_back(2);
        step(); event_v = 4'b0000;
        wait_idle("t6");

        // 7: edge-detect instance: a held level yields one event
        e_grants = 0;
        step(); e_event = 4'b0010;
        repeat (4) step();
        e_event = 4'b0000;
        repeat (4) step();
        @(negedge clk);
        check("t7_one_grant", 32'(e_grants), 1);
        check("t7_no_drop", 32'(e_cnt), 0);
        check("t7_idle", 32'(e_busy), 0);
        step(); e_event = 4'b0010;
        step(); e_event = 4'b0000;
        repeat (4) step();
        @(negedge clk);
        check("t7_second_grant", 32'(e_grants), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
